// File: rtl/alu_status_stage.sv
// Execute stage after the shifter: 2-bit ALU op on A and shifted B, result held in C plus Z/N/V,
// presented to the consumer through a one-entry valid/ready buffer.
module alu_status_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic [1:0]       alu_op,
    input  logic             load_c,
    input  logic             load_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c_out,
    output logic             z,
    output logic             n,
    output logic             v
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             z_q, z_d, n_q, n_d, v_q, v_d;

    logic             accept;
    logic [WIDTH-1:0] sum, diff, res;
    logic             res_v;

    // Ready only looks at our own state and the consumer, so no in_valid -> in_ready path.
    assign in_ready = (state_q == StEmpty) | out_ready;
    assign accept   = in_valid & in_ready;

    assign sum  = ain + bin;
    assign diff = ain - bin;

    always_comb begin
        res   = '0;
        res_v = 1'b0;
        unique case (alu_op)
            2'b00: begin
                res   = sum;
                res_v = (ain[WIDTH-1] == bin[WIDTH-1]) & (sum[WIDTH-1] != ain[WIDTH-1]);
            end
            2'b01: begin
                res   = diff;
                res_v = (ain[WIDTH-1] != bin[WIDTH-1]) & (diff[WIDTH-1] != ain[WIDTH-1]);
            end
            2'b10: res = ain & bin;
            2'b11: res = ~bin;
            default: res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        z_d     = z_q;
        n_d     = n_q;
        v_d     = v_q;
        if (accept) begin
            // A same-cycle drain+accept keeps the buffer full with no bubble.
            state_d = StFull;
            if (load_c) begin
                c_d = res;
            end
            if (load_s) begin
                z_d = (res == '0);
                n_d = res[WIDTH-1];
                v_d = res_v;
            end
        end else if ((state_q == StFull) && out_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
            c_q     <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign c_out     = c_q;
    assign z         = z_q;
    assign n         = n_q;
    assign v         = v_q;

endmodule

// File: tb/tb_alu_status_stage.sv
// Randomized and directed bench for alu_status_stage against an integer-arithmetic reference
// model of the buffer and the ALU flags.
module tb_alu_status_stage;

    localparam int W    = 16;
    localparam int MOD  = 2 ** W;
    localparam int MASK = MOD - 1;
    localparam int HALF = 2 ** (W - 1);

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready;
    logic [W-1:0] ain, bin;
    logic [1:0]   alu_op;
    logic         load_c, load_s;
    logic         out_valid, out_ready;
    logic [W-1:0] c_out;
    logic         z, n, v;

    int errors = 0;
    int checks = 0;

    // Reference state
    int m_c;
    bit m_z, m_n, m_v, m_full;

    alu_status_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ain       (ain),
        .bin       (bin),
        .alu_op    (alu_op),
        .load_c    (load_c),
        .load_s    (load_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .z         (z),
        .n         (n),
        .v         (v)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_signed(input int x);
        return (x >= HALF) ? x - MOD : x;
    endfunction

    // Flags from plain signed/unsigned integer arithmetic.
    function automatic void ref_alu(input int a, input int b, input int op,
                                    output int r, output bit fz, output bit fn, output bit fv);
        int s;
        fv = 1'b0;
        r  = 0;
        case (op)
            0: begin
                s  = to_signed(a) + to_signed(b);
                fv = (s > HALF - 1) || (s < -HALF);
                r  = (a + b) % MOD;
            end
            1: begin
                s  = to_signed(a) - to_signed(b);
                fv = (s > HALF - 1) || (s < -HALF);
                r  = (a - b + MOD) % MOD;
            end
            2: r = a & b;
            default: r = MASK - b;
        endcase
        fz = (r == 0);
        fn = (r >= HALF);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".c_out"}, 32'(c_out), 32'(m_c));
        check({tag, ".z"}, 32'(z), 32'(m_z));
        check({tag, ".n"}, 32'(n), 32'(m_n));
        check({tag, ".v"}, 32'(v), 32'(m_v));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_full));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input string tag, input bit iv, input int a, input int b, input int op,
                         input bit lc, input bit ls, input bit ordy);
        bit exp_ready, acc;
        int r;
        bit fz, fn, fv;
        in_valid  = iv;
        ain       = a[W-1:0];
        bin       = b[W-1:0];
        alu_op    = op[1:0];
        load_c    = lc;
        load_s    = ls;
        out_ready = ordy;
        #1;
        exp_ready = !m_full || ordy;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
        acc = iv && exp_ready;
        ref_alu(a, b, op, r, fz, fn, fv);
        @(posedge clk);
        #1;
        if (acc) begin
            m_full = 1'b1;
            if (lc) m_c = r;
            if (ls) begin
                m_z = fz;
                m_n = fn;
                m_v = fv;
            end
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_c    = 0;
        m_z    = 1'b0;
        m_n    = 1'b0;
        m_v    = 1'b0;
        m_full = 1'b0;
    endtask

    initial begin
        int a, b, op;
        reset     = 1'b1;
        in_valid  = 1'b0;
        ain       = '0;
        bin       = '0;
        alu_op    = '0;
        load_c    = 1'b0;
        load_s    = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        check("reset.in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Async reset while full holding 0x1234
        cycle("fill", 1, 'h1234, 0, 0, 1, 1, 0);
        check("fill.c_out_lit", 32'(c_out), 32'h1234);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        check("async_reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed arithmetic
        cycle("add_ovf", 1, 'h7FFF, 'h0001, 0, 1, 1, 1);
        check("add_ovf.c_lit", 32'(c_out), 32'h8000);
        check("add_ovf.v_lit", 32'(v), 32'd1);
        cycle("sub_zero", 1, 'h0005, 'h0005, 1, 1, 1, 1);
        check("sub_zero.z_lit", 32'(z), 32'd1);
        cycle("and", 1, 'hF0CF, 'h0FF0, 2, 1, 1, 1);
        check("and.c_lit", 32'(c_out), 32'h00C0);
        cycle("load_s_only", 1, 'h0003, 'h0003, 1, 0, 1, 1);
        check("load_s_only.c_lit", 32'(c_out), 32'h00C0);
        check("load_s_only.z_lit", 32'(z), 32'd1);
        cycle("not", 1, 0, 'hE19E, 3, 1, 1, 1);
        check("not.c_lit", 32'(c_out), 32'h1E61);
        cycle("no_load", 1, 'h1111, 'h2222, 0, 0, 0, 1);
        cycle("drain", 0, 0, 0, 0, 0, 0, 1);

        // Backpressure: hold full for 3 cycles, then drain+accept in one cycle
        cycle("bp_first", 1, 'h0100, 'h0020, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle("bp_hold", 1, 'h0AAA, 'h0555, 0, 1, 1, 0);
        check("bp_hold.c_lit", 32'(c_out), 32'h0120);
        cycle("bp_release", 1, 'h0AAA, 'h0555, 0, 1, 1, 1);
        check("bp_release.c_lit", 32'(c_out), 32'h0FFF);

        // Back-to-back adds
        for (int i = 0; i < 4; i++) begin
            cycle("b2b", 1, i, 1, 0, 1, 1, 1);
            check("b2b.c_lit", 32'(c_out), 32'(i + 1));
        end

        // Random traffic with boundary-biased operands
        for (int i = 0; i < 400; i++) begin
            a  = ($urandom_range(3) == 0) ? HALF - 1 + int'($urandom_range(2)) : int'($urandom() & MASK);
            b  = ($urandom_range(3) == 0) ? int'($urandom_range(1)) * MASK : int'($urandom() & MASK);
            op = int'($urandom_range(3));
            cycle("rand", $urandom_range(3) != 0, a, b, op, $urandom_range(3) != 0,
                  $urandom_range(3) != 0, $urandom_range(2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
